// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory-game sequencer: FSM states,
// colour index type, one-hot colour decode and LFSR polynomial.
package simon_pkg;

    localparam int                LFSR_W    = 8;
    // Galois form of x^8 + x^6 + x^5 + x^4 + 1, shifting towards bit 0
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef logic [1:0] colour_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GAP      = 3'd1,
        SHOW     = 3'd2,
        WAIT_IN  = 3'd3,
        WAIT_REL = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_t;

    function automatic logic [3:0] onehot4(colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Galois LFSR that supplies new colour entries; it steps
// on every cycle out of reset so the colour depends on when the player acts.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon game sequencer: builds a random colour sequence, replays it and checks presses.
// Define SIMON_TIMEOUT_EN to lose the game when no press arrives within TIMEOUT_CYC cycles.
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int          MAX_LEN     = 16,
    parameter int          SHOW_CYC    = 25_000_000,
    parameter int          GAP_CYC     = 12_500_000,
    parameter int          TIMEOUT_CYC = 150_000_000,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [3:0]                     user_sel,
    input  logic                           button_pressed,
    output logic [3:0]                     led,
    output logic [$clog2(MAX_LEN+1)-1:0]   level,
    output logic                           busy,
    output logic                           game_over,
    output logic                           win
);

    localparam int LW     = $clog2(MAX_LEN + 1);
    localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int SG_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
`ifdef SIMON_TIMEOUT_EN
    localparam int TMR_MAX = (TIMEOUT_CYC > SG_MAX) ? TIMEOUT_CYC : SG_MAX;
`else
    localparam int TMR_MAX = SG_MAX;
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif
    localparam int TW = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
`endif

    state_t            state_q;
    logic [TW-1:0]     timer_q;
    logic [LW-1:0]     idx_q;
    logic [LW-1:0]     len_q;
    colour_t           seq_q [MAX_LEN];
    logic              btn_prev_q;
    logic [3:0]        led_q;
    logic [LW-1:0]     level_q;
    logic              busy_q;
    logic              game_over_q;
    logic              win_q;

    logic [LFSR_W-1:0] lfsr_w;
    logic              unused_lfsr_bits;
    logic [LW-1:0]     idx_inc;
    logic [3:0]        exp_oh;
    logic              press;
    logic              restart;
    logic              rel_done;
    logic              last_entry;
    logic              at_max;
    logic              seq_we;
    logic [IW-1:0]     seq_wa;

    simon_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr_w)
    );

    assign unused_lfsr_bits = ^lfsr_w[LFSR_W-1:2];
    assign idx_inc          = idx_q + LW'(1);
    assign exp_oh           = onehot4(seq_q[idx_q[IW-1:0]]);
    // A press is a rising edge, so a button held into WAIT_IN is never judged.
    assign press            = button_pressed & ~btn_prev_q;
    assign restart          = start && (state_q inside {IDLE, WIN, LOSE});
    assign rel_done         = (state_q == WAIT_REL) && !button_pressed;
    assign last_entry       = !(idx_inc < len_q);
    assign at_max           = (len_q == LW'(MAX_LEN));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        seq_we = 1'b0;
        seq_wa = '0;
        if (restart) begin
            seq_we = 1'b1;
        end else if (rel_done && last_entry && !at_max) begin
            seq_we = 1'b1;
            seq_wa = len_q[IW-1:0];
        end
    end

    // NOTE: the sequence store has no reset; entries are always written before len exposes them.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq_q[seq_wa] <= lfsr_w[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            btn_prev_q  <= 1'b0;
            led_q       <= '0;
            level_q     <= '0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            btn_prev_q <= button_pressed;
            level_q    <= len_q;
            case (state_q)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state_q     <= GAP;
                        len_q       <= LW'(1);
                        idx_q       <= '0;
                        timer_q     <= '0;
                        led_q       <= '0;
                        busy_q      <= 1'b1;
                        game_over_q <= 1'b0;
                        win_q       <= 1'b0;
                    end
                end
                GAP: begin
                    if (timer_q == GAP_LAST) begin
                        timer_q <= '0;
                        if (idx_q < len_q) begin
                            state_q <= SHOW;
                            led_q   <= exp_oh;
                        end else begin
                            state_q <= WAIT_IN;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        timer_q <= '0;
                        idx_q   <= idx_inc;
                        led_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_IN: begin
                    if (press) begin
                        timer_q <= '0;
                        if (user_sel == exp_oh) begin
                            state_q <= WAIT_REL;
                            led_q   <= user_sel;
                        end else begin
                            state_q     <= LOSE;
                            game_over_q <= 1'b1;
                        end
`ifdef SIMON_TIMEOUT_EN
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_q     <= '0;
                        state_q     <= LOSE;
                        game_over_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
`endif
                    end
                end
                WAIT_REL: begin
                    led_q <= user_sel;
                    if (!button_pressed) begin
                        led_q <= '0;
                        if (!last_entry) begin
                            idx_q   <= idx_inc;
                            state_q <= WAIT_IN;
                        end else if (at_max) begin
                            idx_q       <= idx_inc;
                            state_q     <= WIN;
                            game_over_q <= 1'b1;
                            win_q       <= 1'b1;
                        end else begin
                            len_q   <= len_q + LW'(1);
                            idx_q   <= '0;
                            timer_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= GAP;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led       = led_q;
    assign level     = level_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;
    assign win       = win_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Scoreboard bench for simon_round_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_simon_round_ctrl;

    localparam int MAX_LEN = 3;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] led;
        int         lvl;
        logic       busy;
        logic       go;
        logic       win;
    } exp_t;

    typedef enum {M_NONE, M_POKE, M_HOLD} mode_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] user_sel;
    logic       button_pressed;
    logic [3:0] led;
    logic [1:0] level;
    logic       busy;
    logic       game_over;
    logic       win;

    exp_t       sb[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;
    logic [7:0] m;
    logic [1:0] seq_exp [MAX_LEN];

    simon_round_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .SHOW_CYC    (4),
        .GAP_CYC     (2),
        .TIMEOUT_CYC (20),
        .SEED        (8'hA5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .user_sel       (user_sel),
        .button_pressed (button_pressed),
        .led            (led),
        .level          (level),
        .busy           (busy),
        .game_over      (game_over),
        .win            (win)
    );

    always #5 clk = ~clk;

    // Reference LFSR: multiply by x modulo x^8+x^6+x^5+x^4+1 (bit-reversed Galois form).
    always @(posedge clk) begin
        if (reset) m <= 8'hA5;
        else       m <= {1'b0, m[7:1]} ^ (m[0] ? 8'hB8 : 8'h00);
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t       e;
            logic [1:0] lv;
            e  = sb.pop_front();
            lv = e.lvl[1:0];
            n_vec = n_vec + 1;
            if (e.cyc != cyc || led !== e.led || level !== lv || busy !== e.busy ||
                game_over !== e.go || win !== e.win) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @cyc%0d: got led=%b level=%0d busy=%b game_over=%b win=%b, want led=%b level=%0d busy=%b game_over=%b win=%b",
                         e.name, cyc, led, level, busy, game_over, win, e.led, lv, e.busy, e.go, e.win);
            end
        end
    end

    function automatic logic [3:0] oh(logic [1:0] c);
        logic [3:0] r;
        r    = 4'b0000;
        r[c] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k=1 is the output state produced by the most recent clock edge.
    task automatic expect_out(int k, string nm, logic [3:0] l, int lv, logic b, logic g, logic w);
        exp_t e;
        e.cyc = cyc + k; e.name = nm; e.led = l; e.lvl = lv; e.busy = b; e.go = g; e.win = w;
        sb.push_back(e);
    endtask

    task automatic drive_btn(logic [3:0] sel);
        user_sel       = sel;
        button_pressed = |sel;
    endtask

    // Called just after the edge that entered GAP; returns just after the edge entering WAIT_IN.
    task automatic replay(int len, int prev_lvl, mode_t mode);
        int n;
        n = 6 * len + 2;
        for (int j = 0; j < len; j++) begin
            expect_out(6*j + 1, "replay_gap", 4'b0, (j == 0) ? prev_lvl : len, 1'b1, 1'b0, 1'b0);
            expect_out(6*j + 2, "replay_gap", 4'b0, len, 1'b1, 1'b0, 1'b0);
            for (int s = 0; s < 4; s++)
                expect_out(6*j + 3 + s, "replay_show", oh(seq_exp[j]), len, 1'b1, 1'b0, 1'b0);
        end
        expect_out(6*len + 1, "replay_tail", 4'b0, len, 1'b1, 1'b0, 1'b0);
        expect_out(6*len + 2, "replay_tail", 4'b0, len, 1'b1, 1'b0, 1'b0);
        expect_out(6*len + 3, "wait_in_entry", 4'b0, len, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (mode == M_POKE && i == 1) drive_btn(oh(seq_exp[0] + 2'd1));
            if (mode == M_POKE && i == 3) drive_btn(4'b0);
            if (mode == M_HOLD && i == n - 2) drive_btn(oh(seq_exp[0] + 2'd1));
            step();
        end
    endtask

    task automatic start_game(int prev_lvl, mode_t mode);
        seq_exp[0] = m[1:0];
        start = 1'b1;
        step();
        start = 1'b0;
        replay(1, prev_lvl, mode);
    endtask

    task automatic press_ok(int j, int len);
        drive_btn(oh(seq_exp[j]));
        step();
        expect_out(1, "press_echo", oh(seq_exp[j]), len, 1'b0, 1'b0, 1'b0);
        step();
        expect_out(1, "hold_echo", oh(seq_exp[j]), len, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic release_btn(int j, int len);
        drive_btn(4'b0);
        if (j + 1 < len) begin
            step();
            expect_out(1, "release_next", 4'b0, len, 1'b0, 1'b0, 1'b0);
        end else if (len == MAX_LEN) begin
            step();
            expect_out(1, "win", 4'b0, len, 1'b0, 1'b1, 1'b1);
        end else begin
            seq_exp[len] = m[1:0];
            step();
            replay(len + 1, len, M_NONE);
        end
    endtask

    task automatic play_round(int len);
        for (int j = 0; j < len; j++) begin
            press_ok(j, len);
            release_btn(j, len);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; user_sel = 4'b0; button_pressed = 1'b0;
        repeat (3) step();
        expect_out(1, "reset_state", 4'b0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_out(1, "idle", 4'b0, 0, 1'b0, 1'b0, 1'b0);
        end

        // Full game to a win, sequence grows 1 -> 2 -> 3
        start_game(0, M_NONE);
        for (int r = 1; r <= MAX_LEN; r++) play_round(r);

        // Restart from WIN, then a wrong colour in round 2
        start_game(MAX_LEN, M_NONE);
        play_round(1);
        drive_btn(oh(seq_exp[0] + 2'd1));
        step();
        expect_out(1, "wrong_colour", 4'b0, 2, 1'b0, 1'b1, 1'b0);
        drive_btn(4'b0);
        step();
        expect_out(1, "lose_hold", 4'b0, 2, 1'b0, 1'b1, 1'b0);

        // Presses during replay are ignored; a two-bit press loses
        start_game(2, M_POKE);
        drive_btn(4'b0011);
        step();
        expect_out(1, "multi_bit", 4'b0, 1, 1'b0, 1'b1, 1'b0);
        drive_btn(4'b0);
        step();

        // Button held across WAIT_IN entry is not judged
        start_game(1, M_HOLD);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out(1, "held_no_press", 4'b0, 1, 1'b0, 1'b0, 1'b0);
        end
        drive_btn(4'b0);
        step();
        expect_out(1, "held_release", 4'b0, 1, 1'b0, 1'b0, 1'b0);
        play_round(1);
`ifdef SIMON_TIMEOUT_EN
        expect_out(20, "timeout_pending", 4'b0, 2, 1'b0, 1'b0, 1'b0);
        expect_out(21, "timeout_lose", 4'b0, 2, 1'b0, 1'b1, 1'b0);
        repeat (21) step();
`else
        expect_out(30, "no_timeout", 4'b0, 2, 1'b0, 1'b0, 1'b0);
        repeat (30) step();
        press_ok(0, 2);
        release_btn(0, 2);
`endif

        // Reset in the middle of SHOW
        reset = 1'b1;
        step();
        expect_out(1, "reset_again", 4'b0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        seq_exp[0] = m[1:0];
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        expect_out(1, "mid_show", oh(seq_exp[0]), 1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        expect_out(1, "reset_mid_show", 4'b0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        expect_out(1, "after_reset", 4'b0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        if (sb.size() != 0) begin
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
